// File: rtl/conv1_pkg.sv
// Shared defaults, FSM state encoding and frame-geometry helper for the conv1 window reader.
package conv1_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_IMG_W      = 224;
    localparam int unsigned DEF_IMG_H      = 224;

    localparam int unsigned ST_BITS = 3;
    typedef logic [ST_BITS-1:0] conv1_state_t;

    localparam conv1_state_t ST_IDLE    = 3'd0;
    localparam conv1_state_t ST_READ    = 3'd1;
    localparam conv1_state_t ST_CAPTURE = 3'd2;
    localparam conv1_state_t ST_HOLD    = 3'd3;
    localparam conv1_state_t ST_DONE    = 3'd4;

    // Linear index of the last buffer read of a frame (bottom-right valid window origin).
    function automatic int unsigned p_last(input int unsigned img_w, input int unsigned img_h);
        return (img_h - 3) * img_w + img_w - 3;
    endfunction

endpackage

// File: rtl/conv1_pos_counter.sv
// Row/col/linear position counter for the window reader; flags are registered
// alongside the position so they always describe the current row/col.
module conv1_pos_counter
    import conv1_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned ROW_BITS = $clog2(IMG_H),
    parameter int unsigned COL_BITS = $clog2(IMG_W),
    parameter int unsigned POS_BITS = $clog2(IMG_H * IMG_W + 1)
) (
    input  logic                clk,
    input  logic                rst_a_n,
    input  logic                clear,
    input  logic                advance,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col,
    output logic                is_last,
    output logic                in_range
);

    localparam logic [POS_BITS-1:0] POS_LAST = POS_BITS'(p_last(IMG_W, IMG_H));
    localparam logic [COL_BITS-1:0] COL_MAX  = COL_BITS'(IMG_W - 1);
    localparam logic [COL_BITS-1:0] COL_VMAX = COL_BITS'(IMG_W - 3);

    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [POS_BITS-1:0] pos_q, pos_d;
    logic                is_last_q;
    logic                in_range_q;

    // Next position: clear wins over advance; col wraps into the next row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        pos_d = pos_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
            pos_d = '0;
        end else if (advance) begin
            pos_d = pos_q + POS_BITS'(1);
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_q + ROW_BITS'(1);
            end else begin
                col_d = col_q + COL_BITS'(1);
            end
        end
    end

    // Position and derived flags registered together.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            row_q      <= '0;
            col_q      <= '0;
            pos_q      <= '0;
            is_last_q  <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            pos_q      <= pos_d;
            is_last_q  <= (pos_d == POS_LAST);
            in_range_q <= (col_d <= COL_VMAX);
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign is_last  = is_last_q;
    assign in_range = in_range_q;

endmodule

// File: rtl/conv1_window_reader.sv
// Read-side controller for the conv1 3x3 window buffer: reads every position,
// drops row-wrapping windows and hands valid ones downstream on valid/ready.
// Optional build macro CONV1_STRIDE2_EN keeps only even row/col windows and
// reports halved coordinates.
module conv1_window_reader
    import conv1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned ROW_BITS   = $clog2(IMG_H),
    parameter int unsigned COL_BITS   = $clog2(IMG_W)
) (
    input  logic                    clk,
    input  logic                    rst_a_n,
    input  logic                    start,
    input  logic                    buf_empty,
    output logic                    buf_rd_en,
    input  logic [9*DATA_WIDTH-1:0] buf_data,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [ROW_BITS-1:0]     win_row,
    output logic [COL_BITS-1:0]     win_col,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WORD_W   = 9 * DATA_WIDTH;
    localparam int unsigned POS_BITS = $clog2(IMG_H * IMG_W + 1);

    conv1_state_t        state_q, state_d;
    logic [WORD_W-1:0]   win_data_q, win_data_d;
    logic [ROW_BITS-1:0] win_row_q, win_row_d;
    logic [COL_BITS-1:0] win_col_q, win_col_d;
    logic                win_valid_q;
    logic                busy_q;
    logic                done_q;

    logic                rd_en_c;
    logic                cnt_clear_c;
    logic                cnt_advance_c;
    logic                keep_c;
    logic [ROW_BITS-1:0] tag_row_c;
    logic [COL_BITS-1:0] tag_col_c;

    logic [ROW_BITS-1:0] pos_row;
    logic [COL_BITS-1:0] pos_col;
    logic                pos_last;
    logic                pos_in_range;

    conv1_pos_counter #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .POS_BITS (POS_BITS)
    ) u_pos (
        .clk      (clk),
        .rst_a_n  (rst_a_n),
        .clear    (cnt_clear_c),
        .advance  (cnt_advance_c),
        .row      (pos_row),
        .col      (pos_col),
        .is_last  (pos_last),
        .in_range (pos_in_range)
    );

    // Window filter and the coordinates reported with a kept window.
`ifdef CONV1_STRIDE2_EN
    assign keep_c    = pos_in_range & ~pos_row[0] & ~pos_col[0];
    assign tag_row_c = pos_row >> 1;
    assign tag_col_c = pos_col >> 1;
`else
    assign keep_c    = pos_in_range;
    assign tag_row_c = pos_row;
    assign tag_col_c = pos_col;
`endif

    // Next-state, read strobe, counter control and capture mux.
    always_comb begin
        state_d       = state_q;
        rd_en_c       = 1'b0;
        cnt_clear_c   = 1'b0;
        cnt_advance_c = 1'b0;
        win_data_d    = win_data_q;
        win_row_d     = win_row_q;
        win_col_d     = win_col_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_clear_c = 1'b1;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                if (!buf_empty) begin
                    rd_en_c = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                win_data_d = buf_data;
                win_row_d  = tag_row_c;
                win_col_d  = tag_col_c;
                if (keep_c) begin
                    state_d = ST_HOLD;
                end else if (pos_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_advance_c = 1'b1;
                    state_d       = ST_READ;
                end
            end
            ST_HOLD: begin
                if (win_ready) begin
                    if (pos_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_advance_c = 1'b1;
                        state_d       = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags track the state being entered.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q     <= ST_IDLE;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_valid_q <= (state_d == ST_HOLD);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    // Read strobe stays combinational so it can never fire against a just-raised empty flag.
    assign buf_rd_en = rd_en_c;
    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/conv1_window_reader.md
Name: conv1_window_reader

Overview:
- Read-side controller for the conv1 3x3 window buffer.
- Drives the buffer's rd_en, captures the 9-pixel window word one cycle later, and discards windows that wrap across a row edge.
- Presents valid windows downstream on a valid/ready handshake, tagged with output row/col, to feed the conv1 MAC array.
- One frame runs per start pulse.

Parameters:
- DATA_WIDTH, 16, pixel width in bits.
- IMG_W, 224, input feature-map width; the buffer row pitch.
- IMG_H, 224, input feature-map height.
- ROW_BITS, $clog2(IMG_H), width of win_row.
- COL_BITS, $clog2(IMG_W), width of win_col.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_a_n  input  1  asynchronous, active-low reset.
- start  input  1  frame start pulse; sampled only in IDLE.
- buf_empty  input  1  buffer empty flag.
- buf_rd_en  output  1  buffer read strobe; advances the buffer read pointer by 1.
- buf_data  input  9*DATA_WIDTH  buffer window word; valid the cycle after buf_rd_en.
- win_data  output  9*DATA_WIDTH  captured window; top-left pixel in the MSBs.
- win_row  output  ROW_BITS  output row of win_data.
- win_col  output  COL_BITS  output column of win_data.
- win_valid  output  1  window valid.
- win_ready  input  1  downstream accept.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset: all outputs and state are 0, and the FSM is in IDLE.
- Reset mid-frame aborts the frame. No partial done is produced.
- Position counter:
  - row is 0..IMG_H-3 and col is 0..IMG_W-1.
  - It increments on each capture; col wraps to 0 and row increments.
  - Linear position p = row*IMG_W + col.
- Last read position P_LAST = (IMG_H-3)*IMG_W + IMG_W-3.
- Window counts: total reads = P_LAST+1; windows emitted = (IMG_H-2)*(IMG_W-2).
- Window validity: a window is valid iff col <= IMG_W-3. Positions with col >= IMG_W-2 are read (to advance the pointer) and then dropped.
- FSM:
  - IDLE: if start, clear the counters and go to READ. A start received while busy is ignored.
  - READ: if !buf_empty, assert buf_rd_en for exactly one cycle and go to CAPTURE. Otherwise stay in READ with buf_rd_en = 0.
  - CAPTURE:
    - Latch buf_data into win_data and the current row/col into win_row/win_col.
    - If the window is valid (per the validity rule and any feature filter), go to HOLD.
    - Otherwise, if p == P_LAST, go to DONE; else advance the counter and go to READ.
  - HOLD:
    - win_valid = 1. win_data, win_row and win_col stay stable until win_ready.
    - On win_ready, win_valid drops next cycle.
    - Then, if p == P_LAST, go to DONE; else advance the counter and go to READ.
  - DONE: done = 1 for one cycle, then go to IDLE.
- win_valid is registered and never asserted outside HOLD.
- win_valid never drops without a handshake.
- Read-to-data latency is 1 cycle.
- Best-case throughput is 1 window per 3 cycles with win_ready held high.
- buf_rd_en is never asserted while buf_empty = 1, so the buffer is never underflowed.
- Counter and comparison widths are sized to hold IMG_H*IMG_W without overflow.

Optional Feature:
- Macro: CONV1_STRIDE2_EN.
- Defined: a window is valid only if it passes the column rule and both row and col are even. win_row and win_col report row/2 and col/2.
- All P_LAST+1 positions are still read, so the buffer stays aligned for the next frame.
- Not defined: stride 1 as described above.

Decomposition:
- Package conv1_pkg holds:
  - DATA_WIDTH, IMG_W, IMG_H defaults;
  - the FSM state enum (IDLE, READ, CAPTURE, HOLD, DONE);
  - the P_LAST function.
- One sub-module, conv1_pos_counter:
  - inputs clear and advance;
  - outputs row, col, is_last, in_range.

Test Plan:
- IMG_W=5, IMG_H=4, buffer never empty, win_ready=1, start -> 8 buf_rd_en pulses; 6 windows at (r,c) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); positions 3 and 4 dropped; done pulses once; busy returns to 0.
- Same frame with win_ready held low 10 cycles on the first window -> win_valid, win_data and win_row/col stay constant; no buf_rd_en during the hold.
- buf_empty forced high for 5 cycles mid-frame -> buf_rd_en stays 0 during the stall; frame resumes and all 6 windows are still produced in order.
- rst_a_n low asynchronously while in HOLD -> all outputs are 0 immediately; a new start gives a full 6-window frame.
- start pulsed while busy -> ignored; the window count stays 6.
- CONV1_STRIDE2_EN defined, IMG_W=5, IMG_H=4 -> 8 reads; 2 windows with (win_row, win_col) = (0,0) and (0,1); done pulses once.
